uart_stream_mux: RTL

Parametrised multi-channel successor to the single-channel simulated UART bridge. It aggregates CHANNELS independent DUT-side UART byte streams onto one channel-tagged host-side stream in each direction, with per-channel FIFOs and round-robin arbitration, so a single host endpoint (DPI shim or FPGA debug link) serves every UART in the SoC. The block is fully synthesizable and sits between the UART peripherals and the host link.

---
 rtl/uart_stream_mux.sv | 122 ++++++++++++
 1 files changed

// File: rtl/uart_stream_mux.sv
// uart_stream_mux: merges CHANNELS UART byte streams onto one channel-tagged host stream per direction,
// with per-channel FIFOs, a round-robin outbound arbiter and a saturating drop counter for bad inbound tags.
module uart_stream_mux #(
    parameter int DATA_WIDTH = 8,
    parameter int CHANNELS = 4,
    parameter int DEPTH = 8,
    localparam int CW = $clog2(CHANNELS)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [CHANNELS-1:0]            serial_out_valid,
    output logic [CHANNELS-1:0]            serial_out_ready,
    input  logic [CHANNELS*DATA_WIDTH-1:0] serial_out_bits,
    output logic [CHANNELS-1:0]            serial_in_valid,
    input  logic [CHANNELS-1:0]            serial_in_ready,
    output logic [CHANNELS*DATA_WIDTH-1:0] serial_in_bits,
    output logic                           host_tx_valid,
    input  logic                           host_tx_ready,
    output logic [DATA_WIDTH-1:0]          host_tx_bits,
    output logic [CW-1:0]                  host_tx_chan,
    input  logic                           host_rx_valid,
    output logic                           host_rx_ready,
    input  logic [DATA_WIDTH-1:0]          host_rx_bits,
    input  logic [CW-1:0]                  host_rx_chan,
    output logic [7:0]                     drop_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int NW = $clog2(DEPTH + 1);

    logic [1:0] sync;
    logic run;
    logic [CHANNELS-1:0] ofull, oempty, ifull, iempty;
    logic [DATA_WIDTH-1:0] ohead [CHANNELS];
    logic [CW-1:0] grant, last;
    logic found, load, rx_bad;
    int idx;

    // handshakes stay idle until the released reset has passed both synchroniser flops
    always_ff @(posedge clock or negedge reset)
        if (!reset) sync <= 2'b00;
        else sync <= {sync[0], 1'b1};
    assign run = sync[1];

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx = 0;
        for (int i = 1; i <= CHANNELS; i++) begin
            idx = (int'(last) + i) % CHANNELS;
            if (!found && !oempty[idx]) begin
                found = 1'b1;
                grant = CW'(idx);
            end
        end
    end

    assign load = run && found && (!host_tx_valid || host_tx_ready);
    assign rx_bad = int'(host_rx_chan) >= CHANNELS;
    assign host_rx_ready = run && (rx_bad || !ifull[host_rx_chan]);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [DATA_WIDTH-1:0] omem [DEPTH];
        logic [DATA_WIDTH-1:0] imem [DEPTH];
        logic [PW-1:0] owp, orp, iwp, irp;
        logic [NW-1:0] ocnt, icnt;
        logic opush, opop, ipush, ipop;
        assign opush = serial_out_valid[c] && serial_out_ready[c];
        assign opop = load && grant == CW'(c);
        assign ipush = host_rx_valid && host_rx_ready && host_rx_chan == CW'(c);
        assign ipop = serial_in_valid[c] && serial_in_ready[c];
        assign ofull[c] = ocnt == NW'(DEPTH);
        assign oempty[c] = ocnt == '0;
        assign ifull[c] = icnt == NW'(DEPTH);
        assign iempty[c] = icnt == '0;
        assign ohead[c] = omem[orp];
        assign serial_out_ready[c] = run && !ofull[c];
        assign serial_in_valid[c] = !iempty[c];
        assign serial_in_bits[c*DATA_WIDTH +: DATA_WIDTH] = iempty[c] ? '0 : imem[irp];
        always_ff @(posedge clock) begin
            if (opush) omem[owp] <= serial_out_bits[c*DATA_WIDTH +: DATA_WIDTH];
            if (ipush) imem[iwp] <= host_rx_bits;
        end
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                owp <= '0;
                orp <= '0;
                ocnt <= '0;
                iwp <= '0;
                irp <= '0;
                icnt <= '0;
            end else begin
                if (opush) owp <= owp + 1'b1;
                if (opop) orp <= orp + 1'b1;
                ocnt <= ocnt + NW'(opush) - NW'(opop);
                if (ipush) iwp <= iwp + 1'b1;
                if (ipop) irp <= irp + 1'b1;
                icnt <= icnt + NW'(ipush) - NW'(ipop);
            end
        end
    end

    // output register refills on the same edge it is consumed, sustaining one byte per cycle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            host_tx_valid <= 1'b0;
            host_tx_bits <= '0;
            host_tx_chan <= '0;
            last <= '0;
        end else if (load) begin
            host_tx_valid <= 1'b1;
            host_tx_bits <= ohead[grant];
            host_tx_chan <= grant;
            last <= grant;
        end else if (host_tx_ready) begin
            host_tx_valid <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset)
        if (!reset) drop_count <= '0;
        else if (host_rx_valid && host_rx_ready && rx_bad && drop_count != 8'hff) drop_count <= drop_count + 1'b1;
endmodule
